pulse_frame_gen: RTL and testbench

//  Parametrised successor of the 2-channel motor-controller pulse encoder. Serialises NCH

---
 rtl/pulse_frame_gen_if.sv | 26 ++
 rtl/pulse_frame_gen.sv | 207 ++++++++++++++++++++
 tb/tb_pulse_frame_gen.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_frame_gen_if.sv
// Command/pulse-train bundle between a command source and pulse_frame_gen.
interface pulse_frame_gen_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CMD_W = 8
);
    logic                   enable;
    logic [NCH*CMD_W-1:0]   cmd;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   pwm;
    logic                   frame_start;
    logic [3:0]             ch_idx;
    logic                   overrun;

    // Command source / observer side
    modport master (
        output enable, cmd, cmd_valid,
        input  cmd_ready, pwm, frame_start, ch_idx, overrun
    );

    // Pulse generator side
    modport slave (
        input  enable, cmd, cmd_valid,
        output cmd_ready, pwm, frame_start, ch_idx, overrun
    );
endinterface

// File: rtl/pulse_frame_gen.sv
// Framed multi-channel pulse encoder: each channel sends a pulse sized by its command,
// then a fixed gap; the line idles until the frame period ends. Commands are double
// buffered and only take effect at frame start.
// Optional feature: define SLEW_LIMIT_EN to limit per-frame change of each active command.
module pulse_frame_gen #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CMD_W       = 8,
    parameter int unsigned MIN_TICKS   = 100000,
    parameter int unsigned STEP_TICKS  = 392,
    parameter int unsigned GAP_TICKS   = 110000,
    parameter int unsigned FRAME_TICKS = 1100000,
    parameter int unsigned SLEW_STEP   = 4,
    parameter int unsigned TW          = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    pulse_frame_gen_if.slave bus
);

    localparam int unsigned   CHW      = 4;
    localparam logic [TW-1:0] FT_LAST  = TW'(FRAME_TICKS - 1);
    localparam logic [TW-1:0] FT_MAX   = '1;
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] MIN_W    = TW'(MIN_TICKS);
    localparam logic [TW-1:0] STEP_W   = TW'(STEP_TICKS);
    localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_SYNC
    } state_t;

    state_t                     state_q, state_d;
    logic [TW-1:0]              ft_q, ft_d;
    logic [TW-1:0]              cnt_q, cnt_d;
    logic [CHW-1:0]             ch_q, ch_d;
    logic                       late_q, late_d;
    logic                       pwm_q, pwm_d;
    logic                       fs_q, fs_d;
    logic                       ready_q, ready_d;
    logic                       ovr_q, ovr_d;
    logic [NCH-1:0][CMD_W-1:0]  shadow_q, shadow_d;
    logic [NCH-1:0][CMD_W-1:0]  active_q, active_d;

    logic [CMD_W-1:0]           cur_cmd;
    logic [TW-1:0]              pulse_last;
    logic                       frame_end;
    logic                       start;

`ifdef SLEW_LIMIT_EN
    // Move act toward tgt by at most SLEW_STEP, never past tgt and never wrapping
    function automatic logic [CMD_W-1:0] slew(input logic [CMD_W-1:0] act,
                                              input logic [CMD_W-1:0] tgt);
        logic [31:0] a;
        logic [31:0] t;
        logic [31:0] s;
        a = 32'(act);
        t = 32'(tgt);
        s = 32'(SLEW_STEP);
        if (t > a + s)      return CMD_W'(a + s);
        else if (a > t + s) return CMD_W'(a - s);
        else                return tgt;
    endfunction
`endif

    // Active command of the channel on the line and the last tick of its pulse
    always_comb begin
        cur_cmd = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_q == CHW'(k)) cur_cmd = active_q[k];
        end
        pulse_last = MIN_W + TW'(cur_cmd) * STEP_W - TW'(1);
    end

    // Next-state, timers, command buffers and registered outputs
    always_comb begin
        state_d   = state_q;
        ft_d      = ft_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        late_d    = late_q;
        pwm_d     = pwm_q;
        fs_d      = 1'b0;
        ready_d   = 1'b1;
        ovr_d     = ovr_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        frame_end = 1'b0;
        start     = 1'b0;

        if (bus.cmd_valid && ready_q) shadow_d = bus.cmd;

        // Frame timer runs outside IDLE and saturates rather than wrapping
        if (state_q == S_IDLE)  ft_d = '0;
        else if (ft_q != FT_MAX) ft_d = ft_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.enable) start = 1'b1;
            end
            S_PULSE: begin
                if (ft_q == FT_LAST) begin
                    late_d = 1'b1;
                    ovr_d  = 1'b1;
                end
                if (cnt_q == pulse_last) begin
                    state_d = S_GAP;
                    pwm_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_GAP: begin
                if (ft_q == FT_LAST) begin
                    late_d = 1'b1;
                    ovr_d  = 1'b1;
                end
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (ch_q == CH_LAST) begin
                        // A late frame skips SYNC and restarts right after the last gap
                        if (late_q || ft_q == FT_LAST) frame_end = 1'b1;
                        else                           state_d   = S_SYNC;
                    end else begin
                        state_d = S_PULSE;
                        ch_d    = ch_q + CHW'(1);
                        pwm_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_SYNC: begin
                if (ft_q == FT_LAST) frame_end = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_end) begin
            if (bus.enable) begin
                start = 1'b1;
            end else begin
                state_d = S_IDLE;
                ch_d    = '0;
                pwm_d   = 1'b0;
            end
        end

        // Frame start: promote shadow commands and begin channel 0
        if (start) begin
            state_d = S_PULSE;
            ft_d    = '0;
            cnt_d   = '0;
            ch_d    = '0;
            late_d  = 1'b0;
            pwm_d   = 1'b1;
            fs_d    = 1'b1;
            ready_d = 1'b0;
`ifdef SLEW_LIMIT_EN
            for (int k = 0; k < NCH; k++) begin
                active_d[k] = slew(active_q[k], shadow_q[k]);
            end
`else
            active_d = shadow_q;
`endif
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ft_q     <= '0;
            cnt_q    <= '0;
            ch_q     <= '0;
            late_q   <= 1'b0;
            pwm_q    <= 1'b0;
            fs_q     <= 1'b0;
            ready_q  <= 1'b1;
            ovr_q    <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            ft_q     <= ft_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            late_q   <= late_d;
            pwm_q    <= pwm_d;
            fs_q     <= fs_d;
            ready_q  <= ready_d;
            ovr_q    <= ovr_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign bus.pwm         = pwm_q;
    assign bus.frame_start = fs_q;
    assign bus.ch_idx      = ch_q;
    assign bus.overrun     = ovr_q;
    assign bus.cmd_ready   = ready_q;

endmodule

// File: tb/tb_pulse_frame_gen.sv
// Directed bench for pulse_frame_gen with shortened timing parameters.
module tb_pulse_frame_gen;

    localparam int unsigned NCH     = 4;
    localparam int unsigned CMD_W   = 8;
    localparam int unsigned MIN_T   = 20;
    localparam int unsigned STEP_T  = 1;
    localparam int unsigned GAP_T   = 10;
    localparam int unsigned FRAME_T = 200;
    localparam int unsigned SLEW    = 4;
    localparam int unsigned TW      = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pulse_frame_gen_if #(.NCH(NCH), .CMD_W(CMD_W)) bus ();

    pulse_frame_gen #(
        .NCH(NCH), .CMD_W(CMD_W), .MIN_TICKS(MIN_T), .STEP_TICKS(STEP_T),
        .GAP_TICKS(GAP_T), .FRAME_TICKS(FRAME_T), .SLEW_STEP(SLEW), .TW(TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Pulse-train observer: rise cycles, channel at rise, high widths, frame-start cycles
    int   cyc = 0;
    logic pwm_prev = 1'b0;
    int   rise_q[$];
    int   rch_q[$];
    int   wid_q[$];
    int   fs_q[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.pwm === 1'b1 && pwm_prev !== 1'b1) begin
            rise_q.push_back(cyc);
            rch_q.push_back(int'(bus.ch_idx));
        end
        if (bus.pwm !== 1'b1 && pwm_prev === 1'b1) wid_q.push_back(cyc - rise_q[$]);
        if (bus.frame_start === 1'b1) fs_q.push_back(cyc);
        pwm_prev = bus.pwm;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_new_frame(output int fb);
        int n0;
        int t;
        n0 = fs_q.size();
        t  = 0;
        while (fs_q.size() == n0 && t < 2000) begin
            step();
            t++;
        end
        if (fs_q.size() == n0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_wait: no FRAME_START within %0d cycles", t);
        end
        fb = fs_q.size() - 1;
    endtask

    function automatic logic [NCH*CMD_W-1:0] pack4(input int c0, input int c1,
                                                   input int c2, input int c3);
        return {CMD_W'(c3), CMD_W'(c2), CMD_W'(c1), CMD_W'(c0)};
    endfunction

    task automatic test_reset();
        bus.enable    = 1'b0;
        bus.cmd       = '0;
        bus.cmd_valid = 1'b0;
        rst_n         = 1'b0;
        #12;
        vectors++; if (bus.pwm !== 1'b0) begin miscompares++; $display("FAIL reset_pwm: got %b want 0", bus.pwm); end
        vectors++; if (bus.frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs: got %b want 0", bus.frame_start); end
        vectors++; if (bus.ch_idx !== 4'd0) begin miscompares++; $display("FAIL reset_ch: got %0d want 0", bus.ch_idx); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ovr: got %b want 0", bus.overrun); end
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
        step();
        rst_n = 1'b1;
        step(5);
        vectors++; if (bus.pwm !== 1'b0) begin miscompares++; $display("FAIL idle_pwm: got %b want 0", bus.pwm); end
        vectors++; if (fs_q.size() != 0) begin miscompares++; $display("FAIL idle_fs: got %0d starts want 0", fs_q.size()); end
    endtask

    task automatic test_basic();
        int fb;
        int rb;
        int f1;
        int f2;
        bus.enable = 1'b1;
        step();
        vectors++; if (bus.frame_start !== 1'b1) begin miscompares++; $display("FAIL start_fs: got %b want 1", bus.frame_start); end
        vectors++; if (bus.pwm !== 1'b1) begin miscompares++; $display("FAIL start_pwm: got %b want 1", bus.pwm); end
        vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL start_ready: got %b want 0", bus.cmd_ready); end
        fb = fs_q.size() - 1;
        rb = rise_q.size() - 1;
        step();
        vectors++; if (bus.frame_start !== 1'b0) begin miscompares++; $display("FAIL fs_strobe: got %b want 0", bus.frame_start); end
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_back: got %b want 1", bus.cmd_ready); end
        wait_new_frame(f1);
        wait_new_frame(f2);
        vectors++; if (rise_q[rb] != fs_q[fb]) begin miscompares++; $display("FAIL fs_align: rise %0d fs %0d", rise_q[rb], fs_q[fb]); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (wid_q[rb+k] != 20) begin miscompares++; $display("FAIL basic_w%0d: got %0d want 20", k, wid_q[rb+k]); end
            vectors++; if (rch_q[rb+k] != k) begin miscompares++; $display("FAIL basic_ch%0d: got %0d want %0d", k, rch_q[rb+k], k); end
            if (k < 3) begin
                vectors++; if (rise_q[rb+k+1] - rise_q[rb+k] != 30) begin miscompares++; $display("FAIL basic_pitch%0d: got %0d want 30", k, rise_q[rb+k+1] - rise_q[rb+k]); end
            end
        end
        vectors++; if (fs_q[fb+1] - fs_q[fb] != 200) begin miscompares++; $display("FAIL basic_period0: got %0d want 200", fs_q[fb+1] - fs_q[fb]); end
        vectors++; if (fs_q[fb+2] - fs_q[fb+1] != 200) begin miscompares++; $display("FAIL basic_period1: got %0d want 200", fs_q[fb+2] - fs_q[fb+1]); end
        vectors++; if (rise_q[rb+4] != fs_q[fb+1]) begin miscompares++; $display("FAIL basic_next: rise %0d fs %0d", rise_q[rb+4], fs_q[fb+1]); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL basic_ovr: got %b want 0", bus.overrun); end
    endtask

    task automatic test_enable_drop();
        int fb;
        int rb;
        int t;
        wait_new_frame(fb);
        rb = rise_q.size() - 1;
        t  = 0;
        while (!(bus.ch_idx == 4'd1 && bus.pwm === 1'b1) && t < 100) begin
            step();
            t++;
        end
        bus.enable = 1'b0;
        step(260);
        vectors++; if (fs_q.size() != fb + 1) begin miscompares++; $display("FAIL drop_starts: got %0d want %0d", fs_q.size(), fb + 1); end
        vectors++; if (wid_q.size() != rb + 4) begin miscompares++; $display("FAIL drop_pulses: got %0d want %0d", wid_q.size(), rb + 4); end
        for (int k = 1; k < 4; k++) begin
            vectors++; if (wid_q[rb+k] != 20) begin miscompares++; $display("FAIL drop_w%0d: got %0d want 20", k, wid_q[rb+k]); end
        end
        vectors++; if (bus.pwm !== 1'b0) begin miscompares++; $display("FAIL drop_pwm: got %b want 0", bus.pwm); end
        vectors++; if (bus.ch_idx !== 4'd0) begin miscompares++; $display("FAIL drop_ch: got %0d want 0", bus.ch_idx); end
        bus.enable = 1'b1;
        step();
        vectors++; if (bus.frame_start !== 1'b1) begin miscompares++; $display("FAIL reen_fs: got %b want 1", bus.frame_start); end
        vectors++; if (bus.pwm !== 1'b1) begin miscompares++; $display("FAIL reen_pwm: got %b want 1", bus.pwm); end
        vectors++; if (fs_q.size() != fb + 2) begin miscompares++; $display("FAIL reen_starts: got %0d want %0d", fs_q.size(), fb + 2); end
    endtask

    task automatic test_latency_overrun();
        int fb;
        int rb;
        int f1;
        int f2;
        wait_new_frame(fb);
        rb = rise_q.size() - 1;
        step(3);
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL lat_ready: got %b want 1", bus.cmd_ready); end
        bus.cmd       = pack4(0, 0, 50, 0);
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd       = pack4(0, 0, 255, 0);
        step();
        bus.cmd_valid = 1'b0;
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL lat_ovr0: got %b want 0", bus.overrun); end
        wait_new_frame(f1);
        wait_new_frame(f2);
        vectors++; if (wid_q[rb+2] != 20) begin miscompares++; $display("FAIL lat_sameframe: got %0d want 20", wid_q[rb+2]); end
        vectors++; if (fs_q[fb+1] - fs_q[fb] != 200) begin miscompares++; $display("FAIL lat_period: got %0d want 200", fs_q[fb+1] - fs_q[fb]); end
        vectors++; if (wid_q[rb+6] != 275) begin miscompares++; $display("FAIL lat_nextframe: got %0d want 275", wid_q[rb+6]); end
        vectors++; if (rise_q[rb+6] - fs_q[fb+1] != 60) begin miscompares++; $display("FAIL lat_offset: got %0d want 60", rise_q[rb+6] - fs_q[fb+1]); end
        vectors++; if (fs_q[fb+2] - fs_q[fb+1] != 375) begin miscompares++; $display("FAIL ovr_period: got %0d want 375", fs_q[fb+2] - fs_q[fb+1]); end
        vectors++; if (rise_q[rb+8] - rise_q[rb+7] - wid_q[rb+7] != 10) begin miscompares++; $display("FAIL ovr_lastgap: got %0d want 10", rise_q[rb+8] - rise_q[rb+7] - wid_q[rb+7]); end
        vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
    endtask

    task automatic test_overrun_all();
        int f3;
        int rb;
        int f4;
        step(3);
        bus.cmd       = pack4(255, 255, 255, 255);
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        wait_new_frame(f3);
        rb = rise_q.size() - 1;
        wait_new_frame(f4);
        for (int k = 0; k < 4; k++) begin
            vectors++; if (wid_q[rb+k] != 275) begin miscompares++; $display("FAIL full_w%0d: got %0d want 275", k, wid_q[rb+k]); end
            vectors++; if (rise_q[rb+k+1] - rise_q[rb+k] != 285) begin miscompares++; $display("FAIL full_pitch%0d: got %0d want 285", k, rise_q[rb+k+1] - rise_q[rb+k]); end
        end
        vectors++; if (fs_q[f4] - fs_q[f3] != 1140) begin miscompares++; $display("FAIL full_period: got %0d want 1140", fs_q[f4] - fs_q[f3]); end
        vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL full_ovr: got %b want 1", bus.overrun); end
    endtask

    task automatic test_reset_mid();
        int t;
        int nfs;
        int fa;
        int ra;
        int fb;
        t = 0;
        while (bus.pwm !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        bus.enable = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.pwm !== 1'b0) begin miscompares++; $display("FAIL async_pwm: got %b want 0", bus.pwm); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL async_ovr: got %b want 0", bus.overrun); end
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL async_ready: got %b want 1", bus.cmd_ready); end
        vectors++; if (bus.ch_idx !== 4'd0) begin miscompares++; $display("FAIL async_ch: got %0d want 0", bus.ch_idx); end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        nfs   = fs_q.size();
        step(30);
        vectors++; if (bus.pwm !== 1'b0) begin miscompares++; $display("FAIL postrst_pwm: got %b want 0", bus.pwm); end
        vectors++; if (fs_q.size() != nfs) begin miscompares++; $display("FAIL postrst_fs: got %0d want %0d", fs_q.size(), nfs); end
        bus.enable = 1'b1;
        wait_new_frame(fa);
        ra = rise_q.size() - 1;
        wait_new_frame(fb);
        for (int k = 0; k < 4; k++) begin
            vectors++; if (wid_q[ra+k] != 20) begin miscompares++; $display("FAIL postrst_w%0d: got %0d want 20", k, wid_q[ra+k]); end
        end
        vectors++; if (fs_q[fb] - fs_q[fa] != 200) begin miscompares++; $display("FAIL postrst_period: got %0d want 200", fs_q[fb] - fs_q[fa]); end
    endtask

    task automatic test_cmd_update();
        int fb;
        int rb;
        int fx;
        int exp_w[3];
`ifdef SLEW_LIMIT_EN
        exp_w = '{24, 28, 30};
`else
        exp_w = '{30, 30, 30};
`endif
        wait_new_frame(fb);
        rb = rise_q.size() - 1;
        step(3);
        bus.cmd       = pack4(10, 0, 0, 0);
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        repeat (4) wait_new_frame(fx);
        vectors++; if (wid_q[rb] != 20) begin miscompares++; $display("FAIL upd_frame0: got %0d want 20", wid_q[rb]); end
        for (int j = 1; j <= 3; j++) begin
            vectors++; if (wid_q[rb+4*j] != exp_w[j-1]) begin miscompares++; $display("FAIL upd_frame%0d: got %0d want %0d", j, wid_q[rb+4*j], exp_w[j-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable_drop();
        test_latency_overrun();
        test_overrun_all();
        test_reset_mid();
        test_cmd_update();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
